// File: rtl/alu_ctrl_exec_pkg.sv
// Shared op codes, ALUOp classes, funct encodings and FSM state type for the ALU control/execute block.
package alu_ctrl_exec_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1100
  } alu_opc_e;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // {funct7[5], funct3}
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b1000;
  localparam logic [3:0] F_AND  = 4'b0111;
  localparam logic [3:0] F_OR   = 4'b0110;
  localparam logic [3:0] F_XOR  = 4'b0100;
  localparam logic [3:0] F_SLL  = 4'b0001;
  localparam logic [3:0] F_SRL  = 4'b0101;
  localparam logic [3:0] F_SRA  = 4'b1101;
  localparam logic [3:0] F_SLT  = 4'b0010;
  localparam logic [3:0] F_SLTU = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_exec_if.sv
// Request/result handshake bundle between ID-stage operands and the writeback mux.
interface alu_ctrl_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [3:0]      funct;
  logic            m_sel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      operation;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct, m_sel, a, b, out_ready,
    input  in_ready, out_valid, result, zero, operation, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, m_sel, a, b, out_ready,
    output in_ready, out_valid, result, zero, operation, illegal
  );
endinterface

// File: rtl/alu_ctrl_exec_decode.sv
// Combinational ALUOp/funct/m_sel decoder; every encoding yields a defined op (ADD when illegal).
module alu_op_decode
  import alu_ctrl_exec_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  input  logic       m_sel,
  output alu_opc_e   operation,
  output logic       illegal,
  output logic       is_mul
);

  // Map the instruction class and function bits onto an ALU op code.
  always_comb begin
    operation = OP_ADD;
    illegal   = 1'b0;
    is_mul    = 1'b0;
    case (alu_op)
      ALUOP_LDST: operation = OP_ADD;
      ALUOP_BR:   operation = OP_SUB;
      ALUOP_RTYPE: begin
        if (m_sel) begin
          if ((funct[2:0] == 3'b000) && (MUL_EN != 0)) begin
            operation = OP_MUL;
            is_mul    = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          case (funct)
            F_ADD:   operation = OP_ADD;
            F_SUB:   operation = OP_SUB;
            F_AND:   operation = OP_AND;
            F_OR:    operation = OP_OR;
            F_XOR:   operation = OP_XOR;
            F_SLL:   operation = OP_SLL;
            F_SRL:   operation = OP_SRL;
            F_SRA:   operation = OP_SRA;
            F_SLT:   operation = OP_SLT;
            F_SLTU:  operation = OP_SLTU;
            default: illegal = 1'b1;
          endcase
        end
      end
      default: begin
        // I-type: funct[3] only distinguishes SRA from SRL; no SUB immediate.
        case (funct[2:0])
          F_ADD[2:0]:  operation = OP_ADD;
          F_AND[2:0]:  operation = OP_AND;
          F_OR[2:0]:   operation = OP_OR;
          F_XOR[2:0]:  operation = OP_XOR;
          F_SLL[2:0]:  operation = OP_SLL;
          F_SRL[2:0]:  operation = funct[3] ? OP_SRA : OP_SRL;
          F_SLT[2:0]:  operation = OP_SLT;
          F_SLTU[2:0]: operation = OP_SLTU;
          default:     operation = OP_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_exec.sv
// ALU control/execute: decode at acceptance, single-cycle ops or iterative shift-add MUL, held result.
module alu_ctrl_exec
  import alu_ctrl_exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  alu_ctrl_exec_if.slave  bus
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  state_e          state;
  state_e          state_nxt;
  alu_opc_e        dec_op;
  logic            dec_ill;
  logic            dec_mul;
  logic            in_rdy;
  logic            accept;
  logic            out_vld;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_nxt;
  logic [CW-1:0]   cnt;
  logic            mul_last;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  alu_opc_e        op_q;
  logic            ill_q;

  alu_op_decode #(.MUL_EN(MUL_EN)) u_dec (
    .alu_op    (bus.alu_op),
    .funct     (bus.funct),
    .m_sel     (bus.m_sel),
    .operation (dec_op),
    .illegal   (dec_ill),
    .is_mul    (dec_mul)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: DONE may re-accept back-to-back while its result is being consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = dec_mul ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_nxt = S_DONE;
      S_DONE: begin
        if (accept)             state_nxt = dec_mul ? S_MUL : S_DONE;
        else if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready depends combinationally on out_ready in DONE.
  always_comb begin
    in_rdy  = !reset && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
    accept  = bus.in_valid && in_rdy;
    out_vld = (state == S_DONE);
  end

  // Single-cycle datapath on the live operands at acceptance.
  always_comb begin
    shamt = bus.b[SW-1:0];
    case (dec_op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLT:  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: alu_res = XLEN'(bus.a < bus.b);
      default: alu_res = bus.a + bus.b;
    endcase
  end

  // One multiplier bit per cycle; last iteration when counter reaches XLEN-1.
  always_comb begin
    acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    mul_last = (cnt == CW'(XLEN - 1));
  end

  // Result/operand registers; result only updates on acceptance or MUL completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      op_q     <= OP_AND;
      ill_q    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      op_q  <= dec_op;
      ill_q <= dec_ill;
      if (dec_mul) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        result_q <= acc_nxt;
        zero_q   <= (acc_nxt == '0);
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.operation = op_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed self-checking bench for alu_ctrl_exec (MUL_EN=1 main instance, MUL_EN=0 side instance).
module tb_alu_ctrl_exec;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  logic ok;

  alu_ctrl_exec_if #(.XLEN(32)) bus ();
  alu_ctrl_exec_if #(.XLEN(32)) bus0 ();

  alu_ctrl_exec #(.XLEN(32), .MUL_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_ctrl_exec #(.XLEN(32), .MUL_EN(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic ms,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = f;
    bus.m_sel    = ms;
    bus.a        = a;
    bus.b        = b;
  endtask

  // Called at a negedge with the DUT idle and out_ready=1.
  task automatic single(input string tag, input logic [1:0] op, input logic [3:0] f, input logic ms,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] eop, input logic eill);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(op, f, ms, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0BAD_F00D;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(er == 32'h0));
    chk({tag, ".operation"}, 32'(bus.operation), 32'(eop));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(eill));
    @(negedge clk);
    chk({tag, ".idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er);
    int n;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(2'b10, 4'b0000, 1'b1, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd33);
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".operation"}, 32'(bus.operation), 32'hC);
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 4'b0000;
    bus.m_sel     = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.alu_op   = 2'b00;
    bus0.funct    = 4'b0000;
    bus0.m_sel    = 1'b0;
    bus0.a        = 32'h0;
    bus0.b        = 32'h0;
    bus0.out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", bus.result, 32'h0);
    chk("rst.zero", 32'(bus.zero), 32'd0);
    chk("rst.operation", 32'(bus.operation), 32'd0);
    chk("rst.illegal", 32'(bus.illegal), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready_rel", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    single("sub_r",   2'b10, 4'b1000, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1'b0);
    single("add_ld",  2'b00, 4'b1111, 1'b1, 32'd3, 32'd4, 32'd7, 4'b0010, 1'b0);
    single("sub_br",  2'b01, 4'b0000, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0110, 1'b0);
    single("sra_i",   2'b11, 4'b1101, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1000, 1'b0);
    single("srl_i",   2'b11, 4'b0101, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0101, 1'b0);
    single("slt_r",   2'b10, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1'b0);
    single("sltu_r",  2'b10, 4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001, 1'b0);
    single("xor_r",   2'b10, 4'b0100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b0011, 1'b0);
    single("sll_r",   2'b10, 4'b0001, 1'b0, 32'd1, 32'h24, 32'h10, 4'b0100, 1'b0);
    single("or_r",    2'b10, 4'b0110, 1'b0, 32'hF0, 32'h0F, 32'hFF, 4'b0001, 1'b0);
    single("addi_f3", 2'b11, 4'b1000, 1'b0, 32'd10, 32'd5, 32'd15, 4'b0010, 1'b0);
    single("andi",    2'b11, 4'b1111, 1'b0, 32'hFF, 32'h0F, 32'h0F, 4'b0000, 1'b0);

    run_mul("mul_a", 32'h0000_1234, 32'h10, 32'h0001_2340);
    run_mul("mul_b", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
    run_mul("mul_c", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

    // Consumer stall with a pending request, then same-cycle hand-over.
    bus.out_ready = 1'b0;
    drive(2'b00, 4'b0000, 1'b0, 32'd100, 32'd23);
    @(negedge clk);
    drive(2'b10, 4'b0100, 1'b0, 32'hFF, 32'h0F);
    chk("stall.out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall.result", bus.result, 32'd123);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall.hold_result", bus.result, 32'd123);
      chk("stall.hold_valid", 32'(bus.out_valid), 32'd1);
      chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b.out_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b.result", bus.result, 32'h0000_00F0);
    chk("b2b.operation", 32'(bus.operation), 32'd3);
    @(negedge clk);
    chk("b2b.idle", 32'(bus.out_valid), 32'd0);

    single("illegal_r", 2'b10, 4'b1111, 1'b0, 32'd1, 32'd2, 32'd3, 4'b0010, 1'b1);
    single("illegal_m", 2'b10, 4'b0001, 1'b1, 32'd4, 32'd5, 32'd9, 4'b0010, 1'b1);

    // Reset during a MUL; new requests offered mid-MUL must be ignored.
    drive(2'b10, 4'b0000, 1'b1, 32'h0000_1234, 32'h10);
    @(negedge clk);
    drive(2'b00, 4'b0000, 1'b0, 32'd1, 32'd1);
    chk("mulbusy.in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mulbusy.in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.result", bus.result, 32'h0);
    chk("midrst.operation", 32'(bus.operation), 32'd0);
    chk("midrst.illegal", 32'(bus.illegal), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst.in_ready_rel", 32'(bus.in_ready), 32'd1);
    ok = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 1'b0;
      cyc++;
    end
    chk("midrst.discarded", 32'(ok), 32'd1);
    single("post_rst_sub", 2'b10, 4'b1000, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1'b0);

    // MUL encoding on the MUL_EN=0 instance falls back to illegal ADD.
    bus0.in_valid = 1'b1;
    bus0.alu_op   = 2'b10;
    bus0.funct    = 4'b0000;
    bus0.m_sel    = 1'b1;
    bus0.a        = 32'd6;
    bus0.b        = 32'd7;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    chk("nomul.out_valid", 32'(bus0.out_valid), 32'd1);
    chk("nomul.illegal", 32'(bus0.illegal), 32'd1);
    chk("nomul.operation", 32'(bus0.operation), 32'd2);
    chk("nomul.result", bus0.result, 32'd13);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
